mandelbrot_pixel_sink: RTL
==========================

Name: mandelbrot_pixel_sink

Overview:
- Drives the Mandelbrot engine's run/running/finished handshake one pixel at a time and captures each 4-bit ctr_out.
- Packs two pixels per byte into a small FIFO and presents them on a valid/ready byte stream with an end-of-frame marker.
- Sits between the engine and the downstream display/transport logic.
- Issues a new pixel request only when buffer space exists, so the engine is throttled by downstream backpressure.

Parameters:
- WIDTH, 320, pixels per line.
- HEIGHT, 240, lines per frame.
- FIFO_DEPTH, 4, byte entries; power of two, >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  permits issuing new pixel requests; sampled in IDLE only
- run  out  1  single-cycle start request to engine
- running  in  1  engine busy flag
- ctr_in  in  4  engine ctr_out; valid in any cycle running==0 after a pixel
- finished  in  1  engine frame-complete flag; valid alongside ctr_in
- out_data  out  8  packed pixels: first pixel [3:0], second pixel [7:4]
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accept; a byte transfers when out_valid && out_ready
- out_last  out  1  qualifies out_data as the last byte of a frame
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is captured
- frame_error  out  1  see Optional Feature

Behaviour:
- Reset values:
  - run=0, frame_done=0, frame_error=0.
  - FIFO empty, so out_valid=0; out_data and out_last = 0.
  - Half-byte register cleared; state SYNC.
- States:
  - SYNC: run=0. Goes to IDLE in the first cycle running==0. Any result present is discarded; this covers an engine mid-pixel across a sink-only reset.
  - IDLE: run=0. Goes to ISSUE when enable==1 and FIFO count < FIFO_DEPTH; otherwise stays.
  - ISSUE: run=1 for exactly this one cycle, then unconditionally to WAIT_START.
  - WAIT_START: run=0. Goes to WAIT_DONE when running==1. The engine raises running one cycle after sampling run.
  - WAIT_DONE: when running==0, capture ctr_in and finished in that same cycle (see Capture), then go to IDLE.
- Capture:
  - If no half pending: store ctr_in in the half register and set pending. Exception: if finished==1, push {4'h0, ctr_in} with last=1 instead.
  - If half pending: push {ctr_in, half} with last=finished, then clear pending.
  - finished==1 also pulses frame_done in the following cycle and clears pending.
- Space guarantee: at most one push per pixel, and ISSUE requires a free entry, so a push never meets a full FIFO. Pops during the capture cycle are allowed.
- FIFO:
  - 9-bit entries {last, data}; out_data and out_last are driven from the head entry.
  - Simultaneous push and pop is legal in any state; count is unchanged.
- enable deasserted mid-pixel: the current pixel completes and is captured. No new run is issued; the half register is retained.
- run is never asserted while running==1, and never in two consecutive cycles.
- Latency: run to first WAIT_DONE check = 2 cycles. Capture to out_valid = 1 cycle (registered FIFO).
- Reset mid-operation: asynchronous clear of all state and the FIFO, then re-enter SYNC. Frame alignment with the engine is the top level's responsibility; both must be reset together.

Optional Feature:
- Macro: MANDELBROT_SINK_FRAME_CHECK_EN.
- Defined:
  - A pixel counter of $clog2(WIDTH*HEIGHT+1) bits increments per capture.
  - On a capture with finished==1, frame_error is set (sticky until reset) if count+1 != WIDTH*HEIGHT. The counter then clears.
  - frame_error is also set if finished==0 while count+1 == WIDTH*HEIGHT.
- Undefined: no counter; frame_error tied to 0.

Test Plan:
- Single frame, WIDTH=4, HEIGHT=2, behavioural engine returning ctr 1..8, out_ready=1 -> bytes 0x21,0x43,0x65,0x87; out_last only on 0x87; one frame_done pulse; exactly 8 run pulses.
- Odd frame, WIDTH=3, HEIGHT=1, ctr 5,6,7 -> bytes 0x65 then 0x07 with out_last=1.
- Backpressure, FIFO_DEPTH=2, out_ready=0 -> exactly 4 runs issued, then run held 0. Raising out_ready for one transfer -> exactly 2 more runs.
- Reset asserted while engine running=1 -> after release, no run until running falls; the stale ctr is not pushed; FIFO is empty.
- enable dropped during WAIT_DONE -> pixel captured; no further run; raising enable resumes with the pending half byte intact.
- With MANDELBROT_SINK_FRAME_CHECK_EN, WIDTH=4, HEIGHT=2, engine asserting finished on pixel 6 -> frame_error=1, sticky. Without the macro -> frame_error=0.

Source files
------------

// File: rtl/mandelbrot_pixel_sink.sv
// Pixel sink for the Mandelbrot engine: paces run/running handshakes, packs two 4-bit results per byte
// into a small FIFO and streams them out with an end-of-frame flag. Optional frame-length checker: MANDELBROT_SINK_FRAME_CHECK_EN.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_SYNC      | wait for engine to go idle; any result present is dropped
// S_IDLE      | wait for enable and a free FIFO entry
// S_ISSUE     | run pulse (one cycle)
// S_WAIT_START| wait for engine to raise running
// S_WAIT_DONE | wait for running to fall, then capture ctr_in/finished
`timescale 1ns/1ps
module mandelbrot_pixel_sink #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       run,
  input  logic       running,
  input  logic [3:0] ctr_in,
  input  logic       finished,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_done,
  output logic       frame_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mandelbrot_pixel_sink: FIFO_DEPTH must be a power of two >= 2");
  end
  if (WIDTH < 1 || HEIGHT < 1) begin : g_bad_frame
    $error("mandelbrot_pixel_sink: WIDTH and HEIGHT must be >= 1");
  end

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  state_t state, state_nxt;
  logic   capture;

  logic [3:0]    half;
  logic          half_pend;
  logic          push, pop;
  logic [8:0]    push_word;
  logic [8:0]    head;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_SYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    capture   = 1'b0;
    case (state)
      S_SYNC:       if (!running) state_nxt = S_IDLE;
      S_IDLE:       if (enable && count < CW'(FIFO_DEPTH)) state_nxt = S_ISSUE;
      S_ISSUE: begin
        run       = 1'b1;
        state_nxt = S_WAIT_START;
      end
      S_WAIT_START: if (running) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (!running) begin
          capture   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default:      state_nxt = S_SYNC;
    endcase
  end

  // A finished pixel with no partner is flushed alone in the low nibble.
  assign push      = capture && (finished || half_pend);
  assign push_word = half_pend ? {finished, ctr_in, half} : {1'b1, 4'h0, ctr_in};
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half       <= 4'h0;
      half_pend  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= capture && finished;
      if (capture) begin
        if (finished || half_pend) begin
          half_pend <= 1'b0;
        end else begin
          half      <= ctr_in;
          half_pend <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 9'h0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head                 = mem[rd_ptr];
  assign out_valid            = (count != '0);
  assign {out_last, out_data} = out_valid ? head : 9'h0;

`ifdef MANDELBROT_SINK_FRAME_CHECK_EN
  localparam int PIX = WIDTH * HEIGHT;
  localparam int PCW = $clog2(PIX + 1);

  logic [PCW-1:0] pix_cnt;
  logic           at_last;
  logic           err_q;

  assign at_last = ((pix_cnt + PCW'(1)) == PCW'(PIX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt <= '0;
      err_q   <= 1'b0;
    end else if (capture) begin
      if (finished) begin
        if (!at_last) err_q <= 1'b1;
        pix_cnt <= '0;
      end else begin
        if (at_last) err_q <= 1'b1;
        pix_cnt <= pix_cnt + PCW'(1);
      end
    end
  end

  assign frame_error = err_q;
`else
  assign frame_error = 1'b0;
`endif

endmodule
